// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared types for the layer weight fetch sequencer: ROM geometry, FSM states
// and the per-word tag that travels alongside each fetched weight.
package nar_pkg;

    localparam int unsigned ROM_ADDR_W = 8;
    localparam int unsigned ROM_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } wfs_state_t;

    typedef struct packed {
        logic [ROM_ADDR_W-1:0] neuron_idx;
        logic [ROM_ADDR_W-1:0] in_idx;
        logic                  last;
        logic                  is_bias;
    } wfs_tag_t;

endpackage

// File: rtl/weight_fetch_sequencer_skid_buf.sv
// Two-entry FIFO between the ROM read port and the weight stream; accepts a push
// and a pop in the same cycle even when full.
module wfs_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       occ_o
);

    logic [Width-1:0] mem_q [2];
    logic             head_q;
    logic [1:0]       occ_q, occ_d;
    logic             do_push, do_pop, wr_idx;

    always_comb begin
        do_pop  = pop_i && (occ_q != 2'd0);
        do_push = push_i && ((occ_q != 2'd2) || do_pop);
        // When full, the write lands in the slot being vacated by the pop.
        wr_idx  = head_q ^ occ_q[0];
        occ_d   = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_idx] <= push_data_i;
            end
            if (do_pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_d;
        end
    end

    assign head_o = mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Walks the layer weight ROM linearly and streams tagged words to the MAC.
// Define WFS_BIAS_FETCH_EN to append one bias word per neuron (adds w_is_bias_o).
module weight_fetch_sequencer
    import nar_pkg::*;
#(
    parameter int unsigned N           = 10,
    parameter int unsigned Q           = 8,
    parameter int unsigned NUM_INPUTS  = 16,
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ROM_ADDR_W-1:0] base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [N-1:0]          rom_data_i,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [N-1:0]          w_data_o,
    output logic [IDX_W-1:0]      w_in_idx_o,
    output logic [IDX_W-1:0]      w_neuron_idx_o,
    output logic                  w_last_o
`ifdef WFS_BIAS_FETCH_EN
    ,
    output logic                  w_is_bias_o
`endif
);

`ifdef WFS_BIAS_FETCH_EN
    localparam int unsigned BiasWords = 1;
`else
    localparam int unsigned BiasWords = 0;
`endif
    localparam int unsigned WordsPerNeuron = NUM_INPUTS + BiasWords;
    localparam int unsigned TotalWords     = NUM_NEURONS * WordsPerNeuron;
    localparam int unsigned TagW           = $bits(wfs_tag_t);
    localparam int unsigned CntW           = ROM_ADDR_W + 1;

    if (TotalWords > ROM_DEPTH || TotalWords == 0) begin : g_size_check
        $error("weight_fetch_sequencer: total words must be 1..256");
    end
    if (Q >= N) begin : g_q_check
        $error("weight_fetch_sequencer: Q must be smaller than N");
    end

    wfs_state_t            state_q, state_d;
    logic [ROM_ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ROM_ADDR_W-1:0] in_idx_q, in_idx_d;
    logic [ROM_ADDR_W-1:0] neuron_q, neuron_d;
    logic                  pend_q;
    wfs_tag_t              tag_q, tag_d, cur_tag, head_tag;

    logic [1:0]            occ, occ_left;
    logic                  issue, last_issue, pop, in_wrap;
    logic [N+TagW-1:0]     head;

    assign w_valid_o = (occ != 2'd0);
    assign pop       = w_valid_o && w_ready_i;

    always_comb begin
        in_wrap            = (in_idx_q == ROM_ADDR_W'(WordsPerNeuron - 1));
        cur_tag.neuron_idx = neuron_q;
        cur_tag.in_idx     = in_idx_q;
        cur_tag.last       = in_wrap;
`ifdef WFS_BIAS_FETCH_EN
        cur_tag.is_bias    = (in_idx_q == ROM_ADDR_W'(NUM_INPUTS));
`else
        cur_tag.is_bias    = 1'b0;
`endif
        // A slot freed by this cycle's transfer counts as available, which keeps
        // the stream at one word per cycle when the consumer never stalls.
        occ_left   = occ - {1'b0, pop};
        issue      = (state_q == FETCH) && ((occ_left + {1'b0, pend_q}) < 2'd2);
        last_issue = issue && (cnt_q == CntW'(TotalWords - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_d = FETCH;
            FETCH: if (last_issue) state_d = DRAIN;
            DRAIN: if (!pend_q && (occ == 2'd1) && pop) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        in_idx_d = in_idx_q;
        neuron_d = neuron_q;
        tag_d    = tag_q;
        if (state_q == IDLE && start_i) begin
            addr_d   = base_addr_i;
            cnt_d    = '0;
            in_idx_d = '0;
            neuron_d = '0;
        end
        if (issue) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            tag_d  = cur_tag;
            if (in_wrap) begin
                in_idx_d = '0;
                neuron_d = neuron_q + 1'b1;
            end else begin
                in_idx_d = in_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            in_idx_q <= '0;
            neuron_q <= '0;
            pend_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            in_idx_q <= in_idx_d;
            neuron_q <= neuron_d;
            pend_q   <= issue;
            tag_q    <= tag_d;
        end
    end

    wfs_skid_buf #(
        .Width(N + TagW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (pend_q),
        .push_data_i({rom_data_i, tag_q}),
        .pop_i      (pop),
        .head_o     (head),
        .occ_o      (occ)
    );

    assign {w_data_o, head_tag} = head;
    assign rom_addr_o     = addr_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign w_in_idx_o     = IDX_W'(head_tag.in_idx);
    assign w_neuron_idx_o = IDX_W'(head_tag.neuron_idx);
    assign w_last_o       = head_tag.last;
`ifdef WFS_BIAS_FETCH_EN
    assign w_is_bias_o    = head_tag.is_bias;
`else
    logic unused_is_bias;
    assign unused_is_bias = head_tag.is_bias;
`endif

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer with a synchronous ROM model;
// follows the DUT build in WFS_BIAS_FETCH_EN.
module tb_weight_fetch_sequencer;

    localparam int N     = 10;
    localparam int IDX_W = 8;
    localparam int NN    = 2;
`ifdef WFS_BIAS_FETCH_EN
    localparam int NI    = 3;
    localparam int BIAS  = 1;
`else
    localparam int NI    = 4;
    localparam int BIAS  = 0;
`endif
    localparam int WPN   = NI + BIAS;
    localparam int TOTAL = NN * WPN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       base_addr = 8'h00;
    logic             busy, done;
    logic [7:0]       rom_addr;
    logic [N-1:0]     rom_data;
    logic             w_valid;
    logic             w_ready = 1'b0;
    logic [N-1:0]     w_data;
    logic [IDX_W-1:0] w_in_idx, w_neuron_idx;
    logic             w_last;
    logic             w_is_bias;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] rom [256];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

`ifndef WFS_BIAS_FETCH_EN
    assign w_is_bias = 1'b0;
`endif

    weight_fetch_sequencer #(
        .N          (N),
        .Q          (8),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .IDX_W      (IDX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .busy_o        (busy),
        .done_o        (done),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .w_valid_o     (w_valid),
        .w_ready_i     (w_ready),
        .w_data_o      (w_data),
        .w_in_idx_o    (w_in_idx),
        .w_neuron_idx_o(w_neuron_idx),
        .w_last_o      (w_last)
`ifdef WFS_BIAS_FETCH_EN
        ,
        .w_is_bias_o   (w_is_bias)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {4'b0, w_data, w_neuron_idx, w_in_idx, w_last, w_is_bias};
    endfunction

    // Expected {data, neuron, input, last, bias} for the k-th word of a layer.
    function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
        int         ii;
        int         nn;
        logic [7:0] a;
        ii = k % WPN;
        nn = k / WPN;
        a  = base + 8'(k);
        return {4'b0, rom[a], 8'(nn), 8'(ii), 1'(ii == WPN - 1), 1'(BIAS == 1 && ii == NI)};
    endfunction

    task automatic run(input logic [7:0] base, input bit stall, input int restart_cyc,
                       input int abort_at, output int nw, output int nd);
        bit          held;
        logic [31:0] held_v;
        int          issued;
        nw     = 0;
        nd     = 0;
        held   = 1'b0;
        held_v = '0;
        @(posedge clk);
        #1 start = 1'b1;
        base_addr = base;
        w_ready   = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1 start = (cyc == restart_cyc);
            w_ready = stall ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk("hold_valid", 32'(w_valid), 32'd1);
                chk("hold_data", obs(), held_v);
            end
            if (busy) begin
                issued = int'(8'(rom_addr - base));
                chk("outstanding_le_2", 32'(issued - nw <= 2), 32'd1);
            end
            if (w_valid && w_ready) begin
                if (nw < TOTAL) chk("word", obs(), exp_word(base, nw));
                else chk("extra_word", 32'(nw), 32'(TOTAL));
                nw++;
            end
            if (done) nd++;
            held   = w_valid && !w_ready;
            held_v = obs();
            if (abort_at > 0 && nw == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_valid", 32'(w_valid), 32'd0);
                chk("abort_addr", 32'(rom_addr), 32'd0);
                chk("abort_outputs", obs(), 32'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        w_ready = 1'b1;
    endtask

    int nw, nd;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 10'(i) ^ 10'h2A5;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_outputs", obs(), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full rate, cycle-exact: addresses on cycles 1..8, words on 3..10, done on 11
        @(posedge clk);
        #1 start = 1'b1;
        base_addr = 8'h10;
        w_ready   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 8) chk("full_addr", 32'(rom_addr), 32'(8'h10 + 8'(c - 1)));
            chk("full_valid", 32'(w_valid), 32'(c >= 3 && c <= 10));
            if (w_valid && c >= 3) chk("full_word", obs(), exp_word(8'h10, c - 3));
            chk("full_done", 32'(done), 32'(c == 11));
            chk("full_busy", 32'(busy), 32'(c <= 11));
        end

        // Ready pattern 1,0,0,1
        run(8'h10, 1'b1, 0, 0, nw, nd);
        chk("stall_words", 32'(nw), 32'(TOTAL));
        chk("stall_dones", 32'(nd), 32'd1);
        chk("stall_idle", 32'(busy), 32'd0);

        // Address wrap past 0xFF
        run(8'hFE, 1'b0, 0, 0, nw, nd);
        chk("wrap_words", 32'(nw), 32'(TOTAL));
        chk("wrap_dones", 32'(nd), 32'd1);

        // Start while busy is ignored
        run(8'h20, 1'b0, 3, 0, nw, nd);
        chk("restart_words", 32'(nw), 32'(TOTAL));
        chk("restart_dones", 32'(nd), 32'd1);

        // Start coinciding with done is ignored
        run(8'h30, 1'b0, 11, 0, nw, nd);
        chk("start_at_done_words", 32'(nw), 32'(TOTAL));
        chk("start_at_done_dones", 32'(nd), 32'd1);
        chk("start_at_done_idle", 32'(busy), 32'd0);

        // Reset after word 5 aborts, then a fresh layer from the same base
        run(8'h40, 1'b0, 0, 5, nw, nd);
        chk("abort_words", 32'(nw), 32'd5);
        chk("abort_no_done", 32'(nd), 32'd0);
        run(8'h40, 1'b1, 0, 0, nw, nd);
        chk("refetch_words", 32'(nw), 32'(TOTAL));
        chk("refetch_dones", 32'(nd), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
